// File: rtl/sprite_compositor.sv
// sprite_compositor: three-stage pixel compositor for up to NUM_OBJ
// rectangle/circle objects with fixed priority (index 0 wins).
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   pixel_x_i, pixel_y_i    current pixel from the VGA controller
//   display_enable_i        pixel lies in the active area
//   frame_start_i           start-of-vblank pulse; latches object shadows
//   color_mode_i            0 = mono (objects black on white), 1 = colour
//   obj_{x,y,w,h}_i         per-object geometry, object i at [i*COORD_W +: COORD_W]
//   obj_circle_i            per-object circle select (diameter obj_w)
//   obj_color_i, obj_en_i   per-object colour and enable
//   rgb_o, rgb_valid_o      registered colour and its valid, 3-cycle latency
//   hit_o                   registered per-object hit vector aligned with rgb_o
//   overlap_flags_o         objects that overlapped another during the last frame
module sprite_compositor #(
  parameter int unsigned         NUM_OBJ  = 4,
  parameter int unsigned         COORD_W  = 10,
  parameter int unsigned         COLOR_W  = 24,
  parameter logic [COLOR_W-1:0]  BG_COLOR = '0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [COORD_W-1:0]           pixel_x_i,
  input  logic [COORD_W-1:0]           pixel_y_i,
  input  logic                         display_enable_i,
  input  logic                         frame_start_i,
  input  logic                         color_mode_i,
  input  logic [NUM_OBJ*COORD_W-1:0]   obj_x_i,
  input  logic [NUM_OBJ*COORD_W-1:0]   obj_y_i,
  input  logic [NUM_OBJ*COORD_W-1:0]   obj_w_i,
  input  logic [NUM_OBJ*COORD_W-1:0]   obj_h_i,
  input  logic [NUM_OBJ-1:0]           obj_circle_i,
  input  logic [NUM_OBJ*COLOR_W-1:0]   obj_color_i,
  input  logic [NUM_OBJ-1:0]           obj_en_i,
  output logic [COLOR_W-1:0]           rgb_o,
  output logic                         rgb_valid_o,
  output logic [NUM_OBJ-1:0]           hit_o,
  output logic [NUM_OBJ-1:0]           overlap_flags_o
);

  localparam int unsigned CW = COORD_W + 1;      // coordinate sums, no wrap
  localparam int unsigned SW = 2 * COORD_W + 3;  // squared-distance width

  // Shadow copies of the object table, swapped once per frame
  logic [NUM_OBJ*COORD_W-1:0] sh_x_q, sh_y_q, sh_w_q, sh_h_q;
  logic [NUM_OBJ-1:0]         sh_circle_q, sh_en_q;
  logic [NUM_OBJ*COLOR_W-1:0] sh_color_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sh_x_q      <= '0;
      sh_y_q      <= '0;
      sh_w_q      <= '0;
      sh_h_q      <= '0;
      sh_circle_q <= '0;
      sh_en_q     <= '0;
      sh_color_q  <= '0;
    end else if (frame_start_i) begin
      sh_x_q      <= obj_x_i;
      sh_y_q      <= obj_y_i;
      sh_w_q      <= obj_w_i;
      sh_h_q      <= obj_h_i;
      sh_circle_q <= obj_circle_i;
      sh_en_q     <= obj_en_i;
      sh_color_q  <= obj_color_i;
    end
  end

  // Stage 1: rectangle tests and circle distance terms
  logic [NUM_OBJ-1:0] rect_d, circ_d;
  logic [CW-1:0]      dx_d [NUM_OBJ];
  logic [CW-1:0]      dy_d [NUM_OBJ];
  logic [SW-1:0]      rsq_d [NUM_OBJ];

  always_comb begin
    rect_d = '0;
    circ_d = '0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      logic [CW-1:0] px, py, x, y, w, h, r, cx, cy;
      px = CW'(pixel_x_i);
      py = CW'(pixel_y_i);
      x  = CW'(sh_x_q[i*COORD_W +: COORD_W]);
      y  = CW'(sh_y_q[i*COORD_W +: COORD_W]);
      w  = CW'(sh_w_q[i*COORD_W +: COORD_W]);
      h  = CW'(sh_h_q[i*COORD_W +: COORD_W]);
      r  = w >> 1;
      cx = x + r;
      cy = y + r;
      rect_d[i] = sh_en_q[i] && !sh_circle_q[i] &&
                  (px >= x) && (px < x + w) && (py >= y) && (py < y + h);
      circ_d[i] = sh_en_q[i] && sh_circle_q[i];
      dx_d[i]   = (px >= cx) ? px - cx : cx - px;
      dy_d[i]   = (py >= cy) ? py - cy : cy - py;
      rsq_d[i]  = SW'(r) * SW'(r);
    end
  end

  logic                       de1_q, mode1_q;
  logic [NUM_OBJ-1:0]         rect1_q, circ1_q;
  logic [CW-1:0]              dx1_q [NUM_OBJ];
  logic [CW-1:0]              dy1_q [NUM_OBJ];
  logic [SW-1:0]              rsq1_q [NUM_OBJ];
  logic [NUM_OBJ*COLOR_W-1:0] col1_q, col2_q;

  // Colours travel with the pixel so a frame_start during active video
  // cannot recolour pixels already in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      de1_q   <= 1'b0;
      mode1_q <= 1'b0;
      rect1_q <= '0;
      circ1_q <= '0;
      col1_q  <= '0;
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        dx1_q[i]  <= '0;
        dy1_q[i]  <= '0;
        rsq1_q[i] <= '0;
      end
    end else begin
      de1_q   <= display_enable_i;
      mode1_q <= color_mode_i;
      rect1_q <= rect_d;
      circ1_q <= circ_d;
      col1_q  <= sh_color_q;
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        dx1_q[i]  <= dx_d[i];
        dy1_q[i]  <= dy_d[i];
        rsq1_q[i] <= rsq_d[i];
      end
    end
  end

  // Stage 2: circle compare, final hit vector
  logic [NUM_OBJ-1:0] hit2_d, hit2_q;
  logic               de2_q, mode2_q;

  always_comb begin
    hit2_d = '0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      hit2_d[i] = rect1_q[i] ||
                  (circ1_q[i] && (SW'(dx1_q[i]) * SW'(dx1_q[i]) +
                                  SW'(dy1_q[i]) * SW'(dy1_q[i]) <= rsq1_q[i]));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      de2_q   <= 1'b0;
      mode2_q <= 1'b0;
      hit2_q  <= '0;
      col2_q  <= '0;
    end else begin
      de2_q   <= de1_q;
      mode2_q <= mode1_q;
      hit2_q  <= hit2_d;
      col2_q  <= col1_q;
    end
  end

  // Stage 3: priority mux and mono/colour select
  logic [COLOR_W-1:0] rgb_d, rgb_q;
  logic [NUM_OBJ-1:0] hit_d, hit_q;
  logic               valid_q;

  always_comb begin
    logic found;
    found = 1'b0;
    rgb_d = '0;
    hit_d = '0;
    if (de2_q) begin
      hit_d = hit2_q;
      if (mode2_q) begin
        rgb_d = BG_COLOR;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
          if (hit2_q[i] && !found) begin
            rgb_d = col2_q[i*COLOR_W +: COLOR_W];
            found = 1'b1;
          end
        end
      end else begin
        rgb_d = (|hit2_q) ? '0 : '1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rgb_q   <= '0;
      valid_q <= 1'b0;
      hit_q   <= '0;
    end else begin
      rgb_q   <= rgb_d;
      valid_q <= de2_q;
      hit_q   <= hit_d;
    end
  end

  // Overlap accumulation over the final stage
  logic [NUM_OBJ-1:0] upd_d, acc_q, ovl_q;

  always_comb begin
    upd_d = '0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      logic [NUM_OBJ-1:0] others;
      others   = hit_q & ~(NUM_OBJ'(1) << i);
      upd_d[i] = valid_q && hit_q[i] && (|others);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q <= '0;
      ovl_q <= '0;
    end else if (frame_start_i) begin
      ovl_q <= acc_q | upd_d;
      acc_q <= '0;
    end else begin
      acc_q <= acc_q | upd_d;
    end
  end

  assign rgb_o           = rgb_q;
  assign rgb_valid_o     = valid_q;
  assign hit_o           = hit_q;
  assign overlap_flags_o = ovl_q;

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;
  localparam int N  = 4;
  localparam int CW = 10;
  localparam int KW = 24;
  localparam logic [KW-1:0] BG = 24'h000000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [CW-1:0]   pixel_x = '0, pixel_y = '0;
  logic            de = 1'b0, fs = 1'b0, mode = 1'b1;
  logic [N*CW-1:0] ox = '0, oy = '0, ow = '0, oh = '0;
  logic [N-1:0]    oc = '0, oen = '0;
  logic [N*KW-1:0] ocol = '0;
  logic [KW-1:0]   rgb;
  logic            rgb_valid;
  logic [N-1:0]    hit, ovl;

  always #5 clk = ~clk;

  sprite_compositor #(.NUM_OBJ(N), .COORD_W(CW), .COLOR_W(KW), .BG_COLOR(BG)) dut (
    .clk_i(clk), .reset_i(reset),
    .pixel_x_i(pixel_x), .pixel_y_i(pixel_y),
    .display_enable_i(de), .frame_start_i(fs), .color_mode_i(mode),
    .obj_x_i(ox), .obj_y_i(oy), .obj_w_i(ow), .obj_h_i(oh),
    .obj_circle_i(oc), .obj_color_i(ocol), .obj_en_i(oen),
    .rgb_o(rgb), .rgb_valid_o(rgb_valid), .hit_o(hit), .overlap_flags_o(ovl)
  );

  typedef struct packed {
    logic          valid;
    logic [KW-1:0] rgb;
    logic [N-1:0]  hit;
  } exp_t;

  // Reference model: frame-latched object table in plain integers
  int          m_x[N], m_y[N], m_w[N], m_h[N];
  bit          m_c[N], m_en[N];
  logic [KW-1:0] m_col[N];

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [N-1:0] m_acc = '0, cur_upd = '0, exp_ovl = '0;

  function automatic exp_t model(int px, int py, bit d, bit md);
    exp_t e;
    e = '0;
    if (!d) return e;
    e.valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      bit h;
      h = 1'b0;
      if (m_en[i]) begin
        if (m_c[i]) begin
          int r, ddx, ddy;
          r   = m_w[i] / 2;
          ddx = px - (m_x[i] + r);
          ddy = py - (m_y[i] + r);
          h   = (ddx * ddx + ddy * ddy) <= r * r;
        end else begin
          h = px >= m_x[i] && px < m_x[i] + m_w[i] &&
              py >= m_y[i] && py < m_y[i] + m_h[i];
        end
      end
      e.hit[i] = h;
    end
    if (md) begin
      e.rgb = BG;
      for (int i = N - 1; i >= 0; i--) if (e.hit[i]) e.rgb = m_col[i];
    end else begin
      e.rgb = (e.hit != 0) ? 24'h000000 : 24'hFFFFFF;
    end
    return e;
  endfunction

  // Every hit object overlaps something when two or more objects hit
  function automatic logic [N-1:0] upd_of(exp_t e);
    upd_of = '0;
    if (e.valid && $countones(e.hit) >= 2) upd_of = e.hit;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, expv);
    end
  endtask

  task automatic latch();
    for (int i = 0; i < N; i++) begin
      m_x[i]   = int'(ox[i*CW +: CW]);
      m_y[i]   = int'(oy[i*CW +: CW]);
      m_w[i]   = int'(ow[i*CW +: CW]);
      m_h[i]   = int'(oh[i*CW +: CW]);
      m_c[i]   = oc[i];
      m_en[i]  = oen[i];
      m_col[i] = ocol[i*KW +: KW];
    end
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int w, input int h,
                         input bit c, input logic [KW-1:0] col, input bit en);
    ox[i*CW +: CW]   = CW'(x);
    oy[i*CW +: CW]   = CW'(y);
    ow[i*CW +: CW]   = CW'(w);
    oh[i*CW +: CW]   = CW'(h);
    oc[i]            = c;
    ocol[i*KW +: KW] = col;
    oen[i]           = en;
  endtask

  // One pixel per cycle; outputs checked three edges after the pixel entered
  task automatic step(input int px, input int py, input bit d, input bit f, input bit md);
    exp_t e;
    pixel_x = CW'(px);
    pixel_y = CW'(py);
    de      = d;
    fs      = f;
    mode    = md;
    q.push_back(model(px, py, d, md));
    if (f) begin
      exp_ovl = m_acc | cur_upd;
      m_acc   = '0;
      latch();
    end else begin
      m_acc = m_acc | cur_upd;
    end
    @(posedge clk);
    #1;
    fs = 1'b0;
    if (q.size() >= 3) begin
      e = q.pop_front();
      chk("rgb", 32'(rgb), 32'(e.rgb));
      chk("rgb_valid", 32'(rgb_valid), 32'(e.valid));
      chk("hit", 32'(hit), 32'(e.hit));
      cur_upd = upd_of(e);
    end else begin
      cur_upd = '0;
    end
    chk("overlap_flags", 32'(ovl), 32'(exp_ovl));
  endtask

  task automatic probe(input string tag, input int px, input int py, input bit md,
                       input logic [KW-1:0] expv);
    step(px, py, 1'b1, 1'b0, md);
    step(0, 0, 1'b0, 1'b0, md);
    step(0, 0, 1'b0, 1'b0, md);
    chk(tag, 32'(rgb), 32'(expv));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    de    = 1'b0;
    fs    = 1'b0;
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_valid", 32'(rgb_valid), 32'h0);
    chk("rst_hit", 32'(hit), 32'h0);
    chk("rst_ovl", 32'(ovl), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_rgb", 32'(rgb), 32'h0);
    reset = 1'b0;
    q.delete();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0;
      m_c[i] = 1'b0; m_en[i] = 1'b0; m_col[i] = '0;
    end
    m_acc   = '0;
    cur_upd = '0;
    exp_ovl = '0;
  endtask

  initial begin
    #2;
    do_reset();

    // Empty frames: background everywhere
    for (int f = 0; f < 3; f++) begin
      step(0, 0, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 200; k++)
        step($urandom_range(639), $urandom_range(479), ($urandom % 4) != 0, 1'b0, 1'b1);
    end
    chk("empty_ovl", 32'(ovl), 32'h0);

    // Rectangle object 0
    set_obj(0, 40, 100, 10, 70, 1'b0, 24'hFF0000, 1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b1);
    probe("rect_tl", 40, 100, 1'b1, 24'hFF0000);
    probe("rect_br", 49, 169, 1'b1, 24'hFF0000);
    probe("rect_right", 50, 100, 1'b1, BG);
    probe("rect_above", 40, 99, 1'b1, BG);
    probe("rect_below", 49, 170, 1'b1, BG);
    for (int k = 0; k < 150; k++)
      step($urandom_range(30, 60), $urandom_range(90, 180), 1'b1, 1'b0, 1'b1);

    // Circle object 1, mono mode
    set_obj(1, 300, 200, 15, 0, 1'b1, 24'h00FF00, 1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    probe("circ_centre", 307, 207, 1'b0, 24'h000000);
    probe("circ_edge", 314, 207, 1'b0, 24'h000000);
    probe("circ_out", 315, 207, 1'b0, 24'hFFFFFF);
    probe("circ_diag", 312, 212, 1'b0, 24'hFFFFFF);
    for (int k = 0; k < 150; k++)
      step($urandom_range(295, 320), $urandom_range(195, 220), 1'b1, 1'b0, 1'b0);

    // Overlap of objects 0 and 2
    set_obj(2, 42, 110, 20, 20, 1'b0, 24'h0000FF, 1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b1);
    probe("ovl_prio", 45, 120, 1'b1, 24'hFF0000);
    step(0, 0, 1'b0, 1'b1, 1'b1);
    chk("ovl_set", 32'(ovl), 32'h5);
    probe("ovl_obj2", 55, 125, 1'b1, 24'h0000FF);
    step(0, 0, 1'b0, 1'b1, 1'b1);
    chk("ovl_clear", 32'(ovl), 32'h0);

    // Geometry change mid-frame waits for frame_start
    oen[2] = 1'b0;
    step(0, 0, 1'b0, 1'b1, 1'b1);
    probe("mid_before", 45, 130, 1'b1, 24'hFF0000);
    set_obj(0, 200, 100, 10, 70, 1'b0, 24'hFF0000, 1'b1);
    probe("mid_old", 45, 130, 1'b1, 24'hFF0000);
    probe("mid_newpos", 205, 130, 1'b1, BG);
    step(0, 0, 1'b0, 1'b1, 1'b1);
    probe("next_new", 205, 130, 1'b1, 24'hFF0000);
    probe("next_old", 45, 130, 1'b1, BG);

    // Reset while a hit is in stage 2
    step(205, 130, 1'b1, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b1);
    do_reset();
    probe("post_rst_bg", 205, 130, 1'b1, BG);
    step(0, 0, 1'b0, 1'b1, 1'b1);
    probe("post_rst_fs", 205, 130, 1'b1, 24'hFF0000);

    // Randomised objects, pixels, modes and frame_start timing
    for (int k = 0; k < 3000; k++) begin
      if (k % 100 == 0 || ($urandom % 150) == 0) begin
        for (int i = 0; i < N; i++) begin
          int x, y;
          x = (($urandom % 4) == 0) ? 995 + int'($urandom % 29) : int'($urandom % 60);
          y = int'($urandom % 60);
          set_obj(i, x, y, int'($urandom % 30), int'($urandom % 30),
                  bit'($urandom % 2), KW'($urandom), ($urandom % 4) != 0);
        end
      end
      step((($urandom % 4) == 0) ? 1000 + int'($urandom % 24) : int'($urandom % 80),
           int'($urandom % 80), ($urandom % 4) != 0, ($urandom % 60) == 0,
           ($urandom % 8) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
